writeback_unit: RTL and testbench

Final stage of the dual-pipe SPU datapath: consumes the last pipeline-stage outputs of pipe 1 and pipe 2 and drives the two register-file write ports one cycle later. Qualifies each write, resolves same-register write collisions and maintains a per-register pending-write scoreboard. The issue logic uses the scoreboard to stall instructions whose source or target registers still await a result. Also counts retired writebacks.

---
 rtl/writeback_unit.sv | 134 +++++++++++++
 tb/tb_writeback_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Final writeback stage of the dual-pipe SPU: qualifies and registers both
// register-file writes, tracks pending writes in a scoreboard and counts retirements.
module writeback_unit #(
  parameter int unsigned REG_COUNT = 128,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  // Pipe 1 final-stage outputs
  input  logic              regWriteEnable_in1,
  input  logic [DATA_W-1:0] result_in1,
  input  logic [ADDR_W-1:0] readRegisterRT_in1,
  input  logic [2:0]        latency_in1,
  // Pipe 2 final-stage outputs
  input  logic              regWriteEnable_in2,
  input  logic [DATA_W-1:0] result_in2,
  input  logic [ADDR_W-1:0] readRegisterRT_in2,
  input  logic [2:0]        latency_in2,
  // Issue-side scoreboard lookup
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic [ADDR_W-1:0] issue_ra,
  input  logic [ADDR_W-1:0] issue_rb,
  input  logic [ADDR_W-1:0] issue_rc,
  input  logic              issue_rt_we,
  output logic              stall,
  // Register-file write ports
  output logic              wb_we1,
  output logic [ADDR_W-1:0] wb_addr1,
  output logic [DATA_W-1:0] wb_data1,
  output logic              wb_we2,
  output logic [ADDR_W-1:0] wb_addr2,
  output logic [DATA_W-1:0] wb_data2,
  // Status
  output logic              latency_err,
  output logic [CNT_W-1:0]  retire_count
);

  logic                 v1, v2;
  logic                 collision;
  logic                 lat_bad;
  logic                 issue_set;

  logic                 wb_we1_q, wb_we1_d;
  logic                 wb_we2_q, wb_we2_d;
  logic [ADDR_W-1:0]    wb_addr1_q, wb_addr1_d;
  logic [ADDR_W-1:0]    wb_addr2_q, wb_addr2_d;
  logic [DATA_W-1:0]    wb_data1_q, wb_data1_d;
  logic [DATA_W-1:0]    wb_data2_q, wb_data2_d;
  logic [REG_COUNT-1:0] sb_q, sb_d;
  logic                 latency_err_q, latency_err_d;
  logic [CNT_W-1:0]     retire_cnt_q, retire_cnt_d;

  // A write is only legal once the producing pipe reports zero remaining latency.
  assign v1 = regWriteEnable_in1 && (latency_in1 == 3'd0);
  assign v2 = regWriteEnable_in2 && (latency_in2 == 3'd0);

  assign lat_bad = (regWriteEnable_in1 && (latency_in1 != 3'd0)) ||
                   (regWriteEnable_in2 && (latency_in2 != 3'd0));

  // Pipe 2 holds the younger instruction, so it wins a same-register collision.
  assign collision = v1 && v2 && (readRegisterRT_in1 == readRegisterRT_in2);

  // Registered scoreboard only; this cycle's writebacks are not bypassed.
  assign stall = issue_valid &&
                 (sb_q[issue_ra] || sb_q[issue_rb] || sb_q[issue_rc] ||
                  (issue_rt_we && sb_q[issue_rt]));

  assign issue_set = issue_valid && issue_rt_we && !stall;

  always_comb begin
    wb_we1_d   = v1 && !collision;
    wb_we2_d   = v2;
    wb_addr1_d = readRegisterRT_in1;
    wb_addr2_d = readRegisterRT_in2;
    wb_data1_d = result_in1;
    wb_data2_d = result_in2;
  end

  always_comb begin
    sb_d = sb_q;
    if (v1) begin
      sb_d[readRegisterRT_in1] = 1'b0;
    end
    if (v2) begin
      sb_d[readRegisterRT_in2] = 1'b0;
    end
    // Applied after the clears so a same-index set survives.
    if (issue_set) begin
      sb_d[issue_rt] = 1'b1;
    end
  end

  always_comb begin
    latency_err_d = latency_err_q || lat_bad;
    retire_cnt_d  = retire_cnt_q + CNT_W'(v1) + CNT_W'(v2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we1_q      <= 1'b0;
      wb_we2_q      <= 1'b0;
      wb_addr1_q    <= '0;
      wb_addr2_q    <= '0;
      wb_data1_q    <= '0;
      wb_data2_q    <= '0;
      sb_q          <= '0;
      latency_err_q <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      wb_we1_q      <= wb_we1_d;
      wb_we2_q      <= wb_we2_d;
      wb_addr1_q    <= wb_addr1_d;
      wb_addr2_q    <= wb_addr2_d;
      wb_data1_q    <= wb_data1_d;
      wb_data2_q    <= wb_data2_d;
      sb_q          <= sb_d;
      latency_err_q <= latency_err_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  assign wb_we1       = wb_we1_q;
  assign wb_we2       = wb_we2_q;
  assign wb_addr1     = wb_addr1_q;
  assign wb_addr2     = wb_addr2_q;
  assign wb_data1     = wb_data1_q;
  assign wb_data2     = wb_data2_q;
  assign latency_err  = latency_err_q;
  assign retire_count = retire_cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit; a second narrow-counter
// instance exercises retire counter wrap-around.
module tb_writeback_unit;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              we_in1, we_in2;
  logic [DATA_W-1:0] res_in1, res_in2;
  logic [ADDR_W-1:0] rt_in1, rt_in2;
  logic [2:0]        lat_in1, lat_in2;
  logic              issue_valid, issue_rt_we;
  logic [ADDR_W-1:0] issue_rt, issue_ra, issue_rb, issue_rc;

  logic              stall, wb_we1, wb_we2, latency_err;
  logic [ADDR_W-1:0] wb_addr1, wb_addr2;
  logic [DATA_W-1:0] wb_data1, wb_data2;
  logic [31:0]       retire_count;

  logic              n_stall, n_we1, n_we2, n_err;
  logic [ADDR_W-1:0] n_addr1, n_addr2;
  logic [DATA_W-1:0] n_data1, n_data2;
  logic [2:0]        n_count;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_W-1:0] DataDead = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
  localparam logic [DATA_W-1:0] DataA    = {4{32'hAAAA_0001}};
  localparam logic [DATA_W-1:0] DataB    = {4{32'hBBBB_0002}};
  localparam logic [DATA_W-1:0] DataX    = {4{32'h1111_2222}};
  localparam logic [DATA_W-1:0] DataY    = {4{32'h3333_4444}};
  localparam logic [DATA_W-1:0] DataZ    = {4{32'h5555_6666}};

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .regWriteEnable_in1(we_in1), .result_in1(res_in1),
    .readRegisterRT_in1(rt_in1), .latency_in1(lat_in1),
    .regWriteEnable_in2(we_in2), .result_in2(res_in2),
    .readRegisterRT_in2(rt_in2), .latency_in2(lat_in2),
    .issue_valid(issue_valid), .issue_rt(issue_rt), .issue_ra(issue_ra),
    .issue_rb(issue_rb), .issue_rc(issue_rc), .issue_rt_we(issue_rt_we),
    .stall(stall),
    .wb_we1(wb_we1), .wb_addr1(wb_addr1), .wb_data1(wb_data1),
    .wb_we2(wb_we2), .wb_addr2(wb_addr2), .wb_data2(wb_data2),
    .latency_err(latency_err), .retire_count(retire_count)
  );

  writeback_unit #(.CNT_W(3)) dut_narrow (
    .clk(clk), .reset(reset),
    .regWriteEnable_in1(we_in1), .result_in1(res_in1),
    .readRegisterRT_in1(rt_in1), .latency_in1(lat_in1),
    .regWriteEnable_in2(we_in2), .result_in2(res_in2),
    .readRegisterRT_in2(rt_in2), .latency_in2(lat_in2),
    .issue_valid(issue_valid), .issue_rt(issue_rt), .issue_ra(issue_ra),
    .issue_rb(issue_rb), .issue_rc(issue_rc), .issue_rt_we(issue_rt_we),
    .stall(n_stall),
    .wb_we1(n_we1), .wb_addr1(n_addr1), .wb_data1(n_data1),
    .wb_we2(n_we2), .wb_addr2(n_addr2), .wb_data2(n_data2),
    .latency_err(n_err), .retire_count(n_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0;
    we_in1 = 1'b0; we_in2 = 1'b0;
    res_in1 = '0; res_in2 = '0;
    rt_in1 = '0; rt_in2 = '0;
    lat_in1 = 3'd0; lat_in2 = 3'd0;
    issue_valid = 1'b0; issue_rt_we = 1'b0;
    issue_rt = '0; issue_ra = '0; issue_rb = '0; issue_rc = '0;
  endtask

  task automatic test_reset();
    // Everything active during reset: nothing may be written, counted or scoreboarded.
    reset = 1'b1;
    we_in1 = 1'b1; we_in2 = 1'b1; res_in1 = DataA; res_in2 = DataB;
    rt_in1 = 7'd9; rt_in2 = 7'd10; lat_in1 = 3'd0; lat_in2 = 3'd3;
    issue_valid = 1'b1; issue_rt_we = 1'b1; issue_rt = 7'd5;
    tick();
    clear_inputs();
    checks++; if (wb_we1 !== 1'b0 || wb_we2 !== 1'b0) begin
      errors++; $display("FAIL reset_we: got %b%b expected 00", wb_we1, wb_we2);
    end
    checks++; if (wb_addr1 !== '0 || wb_addr2 !== '0) begin
      errors++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", wb_addr1, wb_addr2);
    end
    checks++; if (wb_data1 !== '0 || wb_data2 !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0", wb_data1, wb_data2);
    end
    checks++; if (retire_count !== 32'd0 || latency_err !== 1'b0) begin
      errors++; $display("FAIL reset_status: got cnt %0d err %b expected 0 0",
                         retire_count, latency_err);
    end
    issue_valid = 1'b1; issue_ra = 7'd5;
    #1;
    checks++; if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    clear_inputs();
  endtask

  task automatic test_single_write();
    we_in1 = 1'b1; rt_in1 = 7'd7; res_in1 = DataDead;
    tick();
    clear_inputs();
    checks++; if (wb_we1 !== 1'b1 || wb_addr1 !== 7'd7 || wb_data1 !== DataDead) begin
      errors++; $display("FAIL single_port1: got we %b addr %0d data %h expected 1 7 %h",
                         wb_we1, wb_addr1, wb_data1, DataDead);
    end
    checks++; if (wb_we2 !== 1'b0) begin
      errors++; $display("FAIL single_we2: got %b expected 0", wb_we2);
    end
    checks++; if (retire_count !== 32'd1) begin
      errors++; $display("FAIL single_count: got %0d expected 1", retire_count);
    end
  endtask

  task automatic test_collision();
    we_in1 = 1'b1; rt_in1 = 7'd12; res_in1 = DataA;
    we_in2 = 1'b1; rt_in2 = 7'd12; res_in2 = DataB;
    tick();
    clear_inputs();
    checks++; if (wb_we1 !== 1'b0 || wb_we2 !== 1'b1) begin
      errors++; $display("FAIL coll_we: got %b%b expected 01", wb_we1, wb_we2);
    end
    checks++; if (wb_addr2 !== 7'd12 || wb_data2 !== DataB) begin
      errors++; $display("FAIL coll_port2: got %0d %h expected 12 %h", wb_addr2, wb_data2, DataB);
    end
    checks++; if (retire_count !== 32'd3) begin
      errors++; $display("FAIL coll_count: got %0d expected 3", retire_count);
    end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rt_we = 1'b1; issue_rt = 7'd20;
    #1;
    checks++; if (stall !== 1'b0) begin
      errors++; $display("FAIL sb_first_issue: got stall %b expected 0", stall);
    end
    tick();
    clear_inputs();
    issue_valid = 1'b1; issue_ra = 7'd20;
    #1;
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL sb_ra: got %b expected 1", stall);
    end
    issue_ra = 7'd0; issue_rb = 7'd20;
    #1;
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL sb_rb: got %b expected 1", stall);
    end
    issue_rb = 7'd0; issue_rc = 7'd20;
    #1;
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL sb_rc: got %b expected 1", stall);
    end
    issue_rc = 7'd0; issue_rt = 7'd20; issue_rt_we = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin
      errors++; $display("FAIL sb_rt_no_we: got %b expected 0", stall);
    end
    issue_rt_we = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL sb_rt_we: got %b expected 1", stall);
    end
    issue_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin
      errors++; $display("FAIL sb_not_valid: got %b expected 0", stall);
    end
    // Writeback of r20 while the reader is held: no bypass, still stalled this cycle.
    issue_valid = 1'b1; issue_rt_we = 1'b0; issue_rt = 7'd0; issue_ra = 7'd20;
    we_in2 = 1'b1; rt_in2 = 7'd20; res_in2 = DataX;
    #1;
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL sb_no_bypass: got %b expected 1", stall);
    end
    tick();
    we_in2 = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || wb_we2 !== 1'b1) begin
      errors++; $display("FAIL sb_cleared: got stall %b we2 %b expected 0 1", stall, wb_we2);
    end
    // Same-cycle set and clear of r20: set wins.
    clear_inputs();
    issue_valid = 1'b1; issue_rt_we = 1'b1; issue_rt = 7'd20;
    we_in2 = 1'b1; rt_in2 = 7'd20;
    tick();
    clear_inputs();
    issue_valid = 1'b1; issue_ra = 7'd20;
    #1;
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL sb_set_wins: got %b expected 1", stall);
    end
    clear_inputs();
    we_in1 = 1'b1; rt_in1 = 7'd20;
    tick();
    clear_inputs();
    // A stalled issue must not claim its target.
    issue_valid = 1'b1; issue_rt_we = 1'b1; issue_rt = 7'd40;
    tick();
    issue_rt = 7'd41; issue_ra = 7'd40;
    tick();
    clear_inputs();
    we_in1 = 1'b1; rt_in1 = 7'd40;
    tick();
    clear_inputs();
    issue_valid = 1'b1; issue_ra = 7'd41; issue_rb = 7'd40;
    #1;
    checks++; if (stall !== 1'b0) begin
      errors++; $display("FAIL sb_stalled_ignored: got %b expected 0", stall);
    end
    clear_inputs();
    checks++; if (retire_count !== 32'd7) begin
      errors++; $display("FAIL sb_count: got %0d expected 7", retire_count);
    end
  endtask

  task automatic test_latency_err();
    we_in2 = 1'b1; rt_in2 = 7'd3; lat_in2 = 3'd2; res_in2 = DataY;
    tick();
    clear_inputs();
    checks++; if (wb_we2 !== 1'b0 || latency_err !== 1'b1) begin
      errors++; $display("FAIL lat_flag: got we2 %b err %b expected 0 1", wb_we2, latency_err);
    end
    checks++; if (retire_count !== 32'd7) begin
      errors++; $display("FAIL lat_count: got %0d expected 7", retire_count);
    end
    tick();
    checks++; if (latency_err !== 1'b1) begin
      errors++; $display("FAIL lat_sticky: got %b expected 1", latency_err);
    end
  endtask

  task automatic test_back_to_back();
    we_in1 = 1'b1; rt_in1 = 7'd3; res_in1 = DataX;
    tick();
    checks++; if (wb_we1 !== 1'b1 || wb_addr1 !== 7'd3 || wb_data1 !== DataX) begin
      errors++; $display("FAIL b2b_first: got %b %0d %h expected 1 3 %h",
                         wb_we1, wb_addr1, wb_data1, DataX);
    end
    rt_in1 = 7'd5; res_in1 = DataZ;
    we_in2 = 1'b1; rt_in2 = 7'd4; res_in2 = DataY;
    tick();
    clear_inputs();
    checks++; if (wb_we1 !== 1'b1 || wb_addr1 !== 7'd5 || wb_data1 !== DataZ) begin
      errors++; $display("FAIL b2b_p1: got %b %0d %h expected 1 5 %h",
                         wb_we1, wb_addr1, wb_data1, DataZ);
    end
    checks++; if (wb_we2 !== 1'b1 || wb_addr2 !== 7'd4 || wb_data2 !== DataY) begin
      errors++; $display("FAIL b2b_p2: got %b %0d %h expected 1 4 %h",
                         wb_we2, wb_addr2, wb_data2, DataY);
    end
    checks++; if (retire_count !== 32'd10 || latency_err !== 1'b1) begin
      errors++; $display("FAIL b2b_status: got cnt %0d err %b expected 10 1",
                         retire_count, latency_err);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    clear_inputs();
    checks++; if (latency_err !== 1'b0 || n_count !== 3'd0 || retire_count !== 32'd0) begin
      errors++; $display("FAIL wrap_reset: got err %b narrow %0d cnt %0d expected 0 0 0",
                         latency_err, n_count, retire_count);
    end
    for (int i = 0; i < 7; i++) begin
      we_in1 = 1'b1; rt_in1 = 7'(i + 1);
      tick();
    end
    clear_inputs();
    checks++; if (n_count !== 3'd7) begin
      errors++; $display("FAIL wrap_preload: got %0d expected 7", n_count);
    end
    we_in1 = 1'b1; rt_in1 = 7'd1; we_in2 = 1'b1; rt_in2 = 7'd2;
    tick();
    clear_inputs();
    checks++; if (n_count !== 3'd1) begin
      errors++; $display("FAIL wrap_narrow: got %0d expected 1", n_count);
    end
    checks++; if (retire_count !== 32'd9) begin
      errors++; $display("FAIL wrap_wide: got %0d expected 9", retire_count);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_collision();
    test_scoreboard();
    test_latency_err();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
